// File: rtl/audio_pingpong_arbiter.sv
// audio_pingpong_arbiter
// Two-bank (ping-pong) byte buffer between an audio stream producer and the
// codec-side consumer. The producer fills one bank while the consumer drains
// the other. Full banks are handed over with a filled/take handshake and
// returned with an empty/ack handshake. A short final bank is zero-padded,
// and a release that finds no full bank waiting counts as an underrun.
module audio_pingpong_arbiter #(
  parameter int BUFFER_SIZE_BYTES = 512,
  parameter int BUFFER_ADDR_BITS  = $clog2(BUFFER_SIZE_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prod_valid_i,
  input  logic [7:0]                  prod_data_i,
  input  logic                        prod_last_i,
  output logic                        prod_ready_o,
  output logic                        buff_filled_o,
  input  logic                        buff_take_i,
  output logic                        buff_sel_o,
  input  logic [BUFFER_ADDR_BITS-1:0] buff_addr_i,
  output logic [7:0]                  buff_data_o,
  input  logic                        buff_empty_i,
  output logic                        buff_empty_ack_o,
  output logic [7:0]                  underrun_cnt_o
);

  typedef enum logic [1:0] {
    B_FREE = 2'd0,
    B_FILL = 2'd1,
    B_FULL = 2'd2,
    B_READ = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_FILL  = 2'd1,
    P_PAD   = 2'd2,
    P_STALL = 2'd3
  } prod_state_e;

  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_OFF = {BUFFER_ADDR_BITS{1'b1}};

  // Sample storage: bank index is the address MSB.
  logic [7:0] mem_q [0:2*BUFFER_SIZE_BYTES-1];

  bank_state_e                 bank_q [2];
  bank_state_e                 bank_d [2];
  prod_state_e                 pstate_q, pstate_d;
  logic                        wr_bank_q, wr_bank_d;
  logic [BUFFER_ADDR_BITS-1:0] wr_off_q, wr_off_d;
  logic                        rd_bank_q, rd_bank_d;
  logic                        ready_q, ready_d;
  logic                        filled_q, filled_d;
  logic                        ack_q, ack_d;
  logic [7:0]                  under_q, under_d;
  logic [7:0]                  rdata_q;

  logic                        mem_we_s;
  logic [7:0]                  mem_wdata_s;
  logic                        complete_s;

  // Next-state logic for the producer FSM, the bank ownership table and the
  // consumer handshake. Both sides decide from the current bank states only,
  // so a bank released this cycle is seen as FREE by the producer next cycle.
  always_comb begin
    bank_d      = bank_q;
    pstate_d    = pstate_q;
    wr_bank_d   = wr_bank_q;
    wr_off_d    = wr_off_q;
    rd_bank_d   = rd_bank_q;
    ack_d       = 1'b0;
    under_d     = under_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = 8'h00;
    complete_s  = 1'b0;

    case (pstate_q)
      P_IDLE: begin
        pstate_d = P_FILL;
      end
      P_FILL: begin
        if (prod_valid_i) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = prod_data_i;
          if (wr_off_q == LAST_OFF) begin
            complete_s = 1'b1;
          end else begin
            wr_off_d = wr_off_q + 1'b1;
            if (prod_last_i) begin
              pstate_d = P_PAD;
            end else begin
              pstate_d = P_FILL;
            end
          end
        end else begin
          pstate_d = P_FILL;
        end
      end
      P_PAD: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = 8'h00;
        if (wr_off_q == LAST_OFF) begin
          complete_s = 1'b1;
        end else begin
          wr_off_d = wr_off_q + 1'b1;
        end
      end
      P_STALL: begin
        if (bank_q[wr_bank_q] == B_FREE) begin
          bank_d[wr_bank_q] = B_FILL;
          pstate_d          = P_FILL;
        end else begin
          pstate_d = P_STALL;
        end
      end
      default: begin
        pstate_d = P_IDLE;
      end
    endcase

    // A completed bank is handed to the consumer side; grab the other bank
    // immediately if it is free, otherwise wait for it.
    if (complete_s) begin
      bank_d[wr_bank_q] = B_FULL;
      wr_bank_d         = ~wr_bank_q;
      wr_off_d          = '0;
      if (bank_q[~wr_bank_q] == B_FREE) begin
        bank_d[~wr_bank_q] = B_FILL;
        pstate_d           = P_FILL;
      end else begin
        pstate_d = P_STALL;
      end
    end else begin
      wr_bank_d = wr_bank_d;
    end

    // Consumer side: claim a full bank, or release the bank being read.
    // The ack_q term keeps a still-high empty level from releasing twice.
    if (bank_q[rd_bank_q] == B_FULL) begin
      if (buff_take_i) begin
        bank_d[rd_bank_q] = B_READ;
      end else begin
        bank_d[rd_bank_q] = B_FULL;
      end
    end else if ((bank_q[rd_bank_q] == B_READ) && buff_empty_i && !ack_q) begin
      bank_d[rd_bank_q] = B_FREE;
      rd_bank_d         = ~rd_bank_q;
      ack_d             = 1'b1;
      if ((bank_q[~rd_bank_q] != B_FULL) && (under_q != 8'hFF)) begin
        under_d = under_q + 8'd1;
      end else begin
        under_d = under_q;
      end
    end else begin
      rd_bank_d = rd_bank_q;
    end

    ready_d  = (pstate_d == P_FILL);
    filled_d = (bank_d[rd_bank_d] == B_FULL);
  end

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= B_FILL;
      bank_q[1] <= B_FREE;
      pstate_q  <= P_IDLE;
      wr_bank_q <= 1'b0;
      wr_off_q  <= '0;
      rd_bank_q <= 1'b0;
      ready_q   <= 1'b0;
      filled_q  <= 1'b0;
      ack_q     <= 1'b0;
      under_q   <= 8'h00;
      rdata_q   <= 8'h00;
    end else begin
      bank_q    <= bank_d;
      pstate_q  <= pstate_d;
      wr_bank_q <= wr_bank_d;
      wr_off_q  <= wr_off_d;
      rd_bank_q <= rd_bank_d;
      ready_q   <= ready_d;
      filled_q  <= filled_d;
      ack_q     <= ack_d;
      under_q   <= under_d;
      rdata_q   <= mem_q[{rd_bank_q, buff_addr_i}];
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[{wr_bank_q, wr_off_q}] <= mem_wdata_s;
    end
  end

  assign prod_ready_o     = ready_q;
  assign buff_filled_o    = filled_q;
  assign buff_sel_o       = rd_bank_q;
  assign buff_data_o      = rdata_q;
  assign buff_empty_ack_o = ack_q;
  assign underrun_cnt_o   = under_q;

endmodule
